// File: rtl/bus_arbiter.sv
// Two-master (ibus, dbus) to one-slave ready/valid arbiter, one transaction outstanding.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin ibus/dbus arbitration; default is dbus-first.
module bus_arbiter #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8,
  parameter int resp_width   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ir_addr_valid,
  output logic                    ir_addr_ready,
  input  logic [addr_width-1:0]   ir_addr,
  output logic                    ir_data_valid,
  input  logic                    ir_data_ready,
  output logic [data_width-1:0]   ir_data,
  input  logic                    dr_addr_valid,
  output logic                    dr_addr_ready,
  input  logic [addr_width-1:0]   dr_addr,
  output logic                    dr_data_valid,
  input  logic                    dr_data_ready,
  output logic [data_width-1:0]   dr_data,
  input  logic                    dw_data_addr_valid,
  output logic                    dw_data_addr_ready,
  input  logic [data_width-1:0]   dw_data,
  input  logic [addr_width-1:0]   dw_addr,
  input  logic [strobe_width-1:0] dw_strobe,
  output logic                    dw_resp_valid,
  input  logic                    dw_resp_ready,
  output logic [resp_width-1:0]   dw_resp,
  output logic                    bus_r_addr_valid,
  input  logic                    bus_r_addr_ready,
  output logic [addr_width-1:0]   bus_r_addr,
  input  logic                    bus_r_data_valid,
  output logic                    bus_r_data_ready,
  input  logic [data_width-1:0]   bus_r_data,
  output logic                    bus_w_data_addr_valid,
  input  logic                    bus_w_data_addr_ready,
  output logic [data_width-1:0]   bus_w_data,
  output logic [addr_width-1:0]   bus_w_addr,
  output logic [strobe_width-1:0] bus_w_strobe,
  input  logic                    bus_w_resp_valid,
  output logic                    bus_w_resp_ready,
  input  logic [resp_width-1:0]   bus_w_resp
);

  // state  | meaning
  // IDLE   | no transaction outstanding, arbitrating upstream requests
  // REQ_I  | ibus read presented downstream
  // REQ_D  | dbus read presented downstream
  // REQ_W  | dbus write presented downstream
  // WAIT_I | forwarding read response to ibus
  // WAIT_D | forwarding read response to dbus
  // WAIT_W | forwarding write response to dbus
  typedef enum logic [2:0] {
    IDLE, REQ_I, REQ_D, REQ_W, WAIT_I, WAIT_D, WAIT_W
  } state_t;

  state_t state_q, state_d;
  logic   r_valid_q, r_valid_d;
  logic   w_valid_q, w_valid_d;

  logic [addr_width-1:0]   r_addr_q;
  logic [addr_width-1:0]   w_addr_q;
  logic [data_width-1:0]   w_data_q;
  logic [strobe_width-1:0] w_strobe_q;

  logic idle, dbus_req, dbus_wins;
  logic grant_i, grant_d, grant_w;
  logic wait_i, wait_d, wait_w;

  assign idle     = (state_q == IDLE) && !reset;
  assign dbus_req = dw_data_addr_valid || dr_addr_valid;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic last_dbus_q, last_dbus_d;

  // On contention the master that was not granted last time wins.
  assign dbus_wins   = dbus_req && (!ir_addr_valid || !last_dbus_q);
  assign last_dbus_d = grant_i ? 1'b0 : ((grant_d || grant_w) ? 1'b1 : last_dbus_q);

  always_ff @(posedge clock) begin
    if (reset) last_dbus_q <= 1'b1;
    else       last_dbus_q <= last_dbus_d;
  end
`else
  assign dbus_wins = dbus_req;
`endif

  assign grant_w = idle && dbus_wins && dw_data_addr_valid;
  assign grant_d = idle && dbus_wins && !dw_data_addr_valid && dr_addr_valid;
  assign grant_i = idle && !dbus_wins && ir_addr_valid;

  assign ir_addr_ready      = grant_i;
  assign dr_addr_ready      = grant_d;
  assign dw_data_addr_ready = grant_w;

  always_comb begin
    state_d   = state_q;
    r_valid_d = r_valid_q;
    w_valid_d = w_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d   = REQ_W;
          w_valid_d = 1'b1;
        end else if (grant_d) begin
          state_d   = REQ_D;
          r_valid_d = 1'b1;
        end else if (grant_i) begin
          state_d   = REQ_I;
          r_valid_d = 1'b1;
        end
      end
      REQ_I: if (bus_r_addr_ready) begin
        state_d   = WAIT_I;
        r_valid_d = 1'b0;
      end
      REQ_D: if (bus_r_addr_ready) begin
        state_d   = WAIT_D;
        r_valid_d = 1'b0;
      end
      REQ_W: if (bus_w_data_addr_ready) begin
        state_d   = WAIT_W;
        w_valid_d = 1'b0;
      end
      WAIT_I: if (bus_r_data_valid && ir_data_ready) state_d = IDLE;
      WAIT_D: if (bus_r_data_valid && dr_data_ready) state_d = IDLE;
      WAIT_W: if (bus_w_resp_valid && dw_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_valid_q <= r_valid_d;
      w_valid_q <= w_valid_d;
    end
  end

  // Payload registers carry no reset; they are only meaningful while a valid is high.
  always_ff @(posedge clock) begin
    if (grant_i)      r_addr_q <= ir_addr;
    else if (grant_d) r_addr_q <= dr_addr;
    if (grant_w) begin
      w_addr_q   <= dw_addr;
      w_data_q   <= dw_data;
      w_strobe_q <= dw_strobe;
    end
  end

  assign bus_r_addr_valid      = r_valid_q;
  assign bus_r_addr            = r_addr_q;
  assign bus_w_data_addr_valid = w_valid_q;
  assign bus_w_addr            = w_addr_q;
  assign bus_w_data            = w_data_q;
  assign bus_w_strobe          = w_strobe_q;

  assign wait_i = (state_q == WAIT_I) && !reset;
  assign wait_d = (state_q == WAIT_D) && !reset;
  assign wait_w = (state_q == WAIT_W) && !reset;

  assign ir_data_valid = wait_i && bus_r_data_valid;
  assign ir_data       = bus_r_data;
  assign dr_data_valid = wait_d && bus_r_data_valid;
  assign dr_data       = bus_r_data;
  assign dw_resp_valid = wait_w && bus_w_resp_valid;
  assign dw_resp       = bus_w_resp;

  // Responses arriving with no owner are accepted and dropped.
  assign bus_r_data_ready = wait_i ? ir_data_ready : (wait_d ? dr_data_ready : 1'b1);
  assign bus_w_resp_ready = wait_w ? dw_resp_ready : 1'b1;

endmodule
